sbox_lookup_engine: RTL and testbench

//   Sequential, parametrised S-box unit for the S-DES datapath. Holds NUM_BOXES runtime-loadable tables.

---
 rtl/sbox_lookup_engine_pkg.sv | 40 ++++
 rtl/sbox_lookup_engine_if.sv | 31 +++
 rtl/sbox_lookup_engine_table.sv | 66 ++++++
 rtl/sbox_lookup_engine.sv | 115 +++++++++++
 tb/tb_sbox_lookup_engine.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/sbox_lookup_engine_pkg.sv
// Shared S-DES S-box constants, FSM state type and index helper for sbox_lookup_engine.
package sdes_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic [1:0] SBOX_S0 [16] = '{
        2'd1, 2'd0, 2'd3, 2'd2,
        2'd3, 2'd2, 2'd1, 2'd0,
        2'd0, 2'd2, 2'd1, 2'd3,
        2'd3, 2'd1, 2'd3, 2'd2
    };

    localparam logic [1:0] SBOX_S1 [16] = '{
        2'd0, 2'd1, 2'd2, 2'd3,
        2'd2, 2'd0, 2'd1, 2'd3,
        2'd3, 2'd0, 2'd1, 2'd0,
        2'd2, 2'd1, 2'd0, 2'd3
    };

    // Outer bits form the row, inner bits the column: idx = {row, col}.
    function automatic logic [31:0] sbox_idx(input logic [31:0] din, input int in_w);
        logic [31:0] row;
        logic [31:0] col;
        row = {30'd0, din[in_w-1], din[0]};
        col = (din >> 1) & ((32'd1 << (in_w - 2)) - 32'd1);
        return (row << (in_w - 2)) | col;
    endfunction

    function automatic logic [1:0] sbox_default(input int box_id, input int i);
        logic [3:0] ix;
        if (i < 0 || i > 15) return 2'd0;
        ix = 4'(i);
        return (box_id % 2 == 0) ? SBOX_S0[ix] : SBOX_S1[ix];
    endfunction

endpackage

// File: rtl/sbox_lookup_engine_if.sv
// Handshake, enable and table-write bus of sbox_lookup_engine.
interface sbox_lookup_engine_if #(
    parameter int NUM_BOXES = 2,
    parameter int IN_W      = 4,
    parameter int OUT_W     = 2
);
    localparam int BOX_W = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1;

    logic                       en;
    logic [NUM_BOXES*IN_W-1:0]  in_data;
    logic                       in_valid;
    logic                       in_ready;
    logic [NUM_BOXES*OUT_W-1:0] out_data;
    logic                       out_valid;
    logic                       out_ready;
    logic                       tbl_we;
    logic [BOX_W-1:0]           tbl_box;
    logic [IN_W-1:0]            tbl_addr;
    logic [OUT_W-1:0]           tbl_wdata;
    logic                       tbl_ready;

    modport master (
        output en, in_data, in_valid, out_ready, tbl_we, tbl_box, tbl_addr, tbl_wdata,
        input  in_ready, out_data, out_valid, tbl_ready
    );

    modport slave (
        input  en, in_data, in_valid, out_ready, tbl_we, tbl_box, tbl_addr, tbl_wdata,
        output in_ready, out_data, out_valid, tbl_ready
    );
endinterface

// File: rtl/sbox_lookup_engine_table.sv
// One runtime-loadable S-box table (sbox_table); SBOX_PARITY_EN adds a per-entry parity bit.
module sbox_table
    import sdes_pkg::*;
#(
    parameter int BOX_ID = 0,
    parameter int IN_W   = 4,
    parameter int OUT_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IN_W-1:0]  waddr,
    input  logic [OUT_W-1:0] wdata,
    input  logic [IN_W-1:0]  raddr,
`ifdef SBOX_PARITY_EN
    output logic             rpar_err,
`endif
    output logic [OUT_W-1:0] rdata
);
    localparam int DEPTH = 2 ** IN_W;
    localparam bit SDES_DEFAULT = (IN_W == 4) && (OUT_W == 2);

    logic [OUT_W-1:0] mem_q [DEPTH];
    logic [OUT_W-1:0] mem_d [DEPTH];

    function automatic logic [OUT_W-1:0] reset_val(input int i);
        if (SDES_DEFAULT) return OUT_W'(sbox_default(BOX_ID, i));
        return '0;
    endfunction

    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end

    assign rdata = mem_q[raddr];

`ifdef SBOX_PARITY_EN
    logic par_q [DEPTH];
    logic par_d [DEPTH];

    // Even parity: stored bit equals the XOR of the data bits.
    always_comb begin
        par_d = par_q;
        if (we) par_d[waddr] = ^wdata;
    end

    assign rpar_err = (^mem_q[raddr]) != par_q[raddr];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= reset_val(i);
`ifdef SBOX_PARITY_EN
                par_q[i] <= ^reset_val(i);
`endif
            end
        end else begin
            mem_q <= mem_d;
`ifdef SBOX_PARITY_EN
            par_q <= par_d;
`endif
        end
    end
endmodule

// File: rtl/sbox_lookup_engine.sv
// Sequential S-box engine: resolves one box per cycle behind valid/ready.
// Optional SBOX_PARITY_EN adds table parity and the sticky par_err output.
module sbox_lookup_engine
    import sdes_pkg::*;
#(
    parameter int NUM_BOXES = 2,
    parameter int IN_W      = 4,
    parameter int OUT_W     = 2
) (
    input  logic clk,
    input  logic rst,
`ifdef SBOX_PARITY_EN
    output logic par_err,
`endif
    sbox_lookup_engine_if.slave bus
);
    localparam int BOX_W = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1;

    state_e                     state_q, state_d;
    logic [BOX_W-1:0]           cnt_q, cnt_d;
    logic [NUM_BOXES*IN_W-1:0]  in_reg_q, in_reg_d;
    logic [NUM_BOXES*OUT_W-1:0] res_q, res_d;
    logic [OUT_W-1:0]           rd [NUM_BOXES];
    logic                       tbl_wr_ok;

    assign tbl_wr_ok = bus.tbl_we && (state_q == IDLE);

`ifdef SBOX_PARITY_EN
    logic par_err_q, par_err_d;
    logic rerr [NUM_BOXES];
    assign par_err = par_err_q;
`endif

    for (genvar b = 0; b < NUM_BOXES; b++) begin : g_box
        logic [IN_W-1:0] raddr;
        assign raddr = IN_W'(sbox_idx(32'(in_reg_q[b*IN_W +: IN_W]), IN_W));

        sbox_table #(
            .BOX_ID (b),
            .IN_W   (IN_W),
            .OUT_W  (OUT_W)
        ) u_tbl (
            .clk      (clk),
            .rst      (rst),
            .we       (tbl_wr_ok && (bus.tbl_box == BOX_W'(b))),
            .waddr    (bus.tbl_addr),
            .wdata    (bus.tbl_wdata),
            .raddr    (raddr),
`ifdef SBOX_PARITY_EN
            .rpar_err (rerr[b]),
`endif
            .rdata    (rd[b])
        );
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        in_reg_d = in_reg_q;
        res_d    = res_q;
`ifdef SBOX_PARITY_EN
        par_err_d = par_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    in_reg_d = bus.in_data;
                    cnt_d    = '0;
                    state_d  = LOOKUP;
                end
            end
            LOOKUP: begin
                res_d[int'(cnt_q)*OUT_W +: OUT_W] = bus.en ? rd[cnt_q] : '0;
`ifdef SBOX_PARITY_EN
                if (rerr[cnt_q]) par_err_d = 1'b1;
`endif
                if (cnt_q == BOX_W'(NUM_BOXES - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + BOX_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            in_reg_q <= '0;
            res_q    <= '0;
`ifdef SBOX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            in_reg_q <= in_reg_d;
            res_q    <= res_d;
`ifdef SBOX_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.tbl_ready = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = res_q;
endmodule

// File: tb/tb_sbox_lookup_engine.sv
// Directed bench for sbox_lookup_engine (default S0/S1 tables, NUM_BOXES=2).
module tb_sbox_lookup_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    sbox_lookup_engine_if #(.NUM_BOXES(2), .IN_W(4), .OUT_W(2)) bus ();

`ifdef SBOX_PARITY_EN
    logic par_err;
`endif

    sbox_lookup_engine #(.NUM_BOXES(2), .IN_W(4), .OUT_W(2)) dut (
        .clk     (clk),
        .rst     (rst),
`ifdef SBOX_PARITY_EN
        .par_err (par_err),
`endif
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_word(input logic [7:0] d, output logic [3:0] res, output bit to);
        int n;
        to = 1'b0;
        n  = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin tick(); n++; end
        if (n >= 20) to = 1'b1;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin tick(); n++; end
        if (n >= 20) to = 1'b1;
        res = bus.out_data;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_vec++; if (bus.out_data !== 4'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        n_vec++; if (bus.tbl_ready !== 1'b1) begin n_err++; $display("FAIL reset_tbl_ready: got %b want 1", bus.tbl_ready); end
    endtask

    task automatic test_basic();
        logic [7:0] vin [3]  = '{8'h00, 8'hFF, 8'h5A};
        logic [3:0] vexp [3] = '{4'b0001, 4'b1110, 4'b0110};
        logic [3:0] res;
        bit to;
        bus.en = 1'b1;
        bus.in_data = 8'h39;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL basic_busy: in_ready got %b want 0", bus.in_ready); end
        tick();
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early: out_valid got %b want 0", bus.out_valid); end
        tick();
        n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL basic_latency: out_valid got %b want 1", bus.out_valid); end
        n_vec++; if (bus.out_data !== 4'b0011) begin n_err++; $display("FAIL basic_39: got %b want 0011", bus.out_data); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_vec++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL basic_release: valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            run_word(vin[i], res, to);
            n_vec++; if (to) begin n_err++; $display("FAIL basic_timeout: word %h got timeout want result", vin[i]); end
            n_vec++; if (res !== vexp[i]) begin n_err++; $display("FAIL basic_word %h: got %b want %b", vin[i], res, vexp[i]); end
        end
    endtask

    task automatic test_backpressure();
        bus.en = 1'b1;
        bus.in_data = 8'hFF;
        bus.in_valid = 1'b1;
        tick();
        bus.in_data = 8'h00;
        tick(); tick();
        n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %b want 1", bus.out_valid); end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid c%0d: got %b want 1", i, bus.out_valid); end
            n_vec++; if (bus.out_data !== 4'b1110) begin n_err++; $display("FAIL bp_hold_data c%0d: got %b want 1110", i, bus.out_data); end
            n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready c%0d: got %b want 0", i, bus.in_ready); end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_en_gating();
        logic [3:0] exp_r [2] = '{4'b1100, 4'b0010};
        for (int k = 0; k < 2; k++) begin
            bus.en = (k == 1);
            bus.in_data = 8'hFF;
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            tick();
            bus.en = (k == 0);
            tick();
            n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL en_valid k%0d: got %b want 1", k, bus.out_valid); end
            n_vec++; if (bus.out_data !== exp_r[k]) begin n_err++; $display("FAIL en_gate k%0d: got %b want %b", k, bus.out_data, exp_r[k]); end
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end
        bus.en = 1'b1;
    endtask

    task automatic test_table_write();
        logic [3:0] res;
        bit to;
        bus.tbl_we = 1'b1; bus.tbl_box = 1'b1; bus.tbl_addr = 4'd5; bus.tbl_wdata = 2'b10;
        tick();
        bus.tbl_we = 1'b0;
        run_word(8'h39, res, to);
        n_vec++; if (to || res !== 4'b1011) begin n_err++; $display("FAIL wr_idle: got %b (to=%0d) want 1011", res, to); end
        bus.in_data = 8'h39;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.tbl_we = 1'b1; bus.tbl_box = 1'b1; bus.tbl_addr = 4'd5; bus.tbl_wdata = 2'b01;
        n_vec++; if (bus.tbl_ready !== 1'b0) begin n_err++; $display("FAIL wr_busy_ready: got %b want 0", bus.tbl_ready); end
        tick(); tick();
        bus.tbl_we = 1'b0;
        n_vec++; if (bus.out_data !== 4'b1011) begin n_err++; $display("FAIL wr_busy_word: got %b want 1011", bus.out_data); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        run_word(8'h39, res, to);
        n_vec++; if (to || res !== 4'b1011) begin n_err++; $display("FAIL wr_busy_ignored: got %b (to=%0d) want 1011", res, to); end
        bus.in_data = 8'h39;
        bus.in_valid = 1'b1;
        bus.tbl_we = 1'b1; bus.tbl_box = 1'b0; bus.tbl_addr = 4'd12; bus.tbl_wdata = 2'b00;
        tick();
        bus.in_valid = 1'b0;
        bus.tbl_we = 1'b0;
        tick(); tick();
        n_vec++; if (bus.out_valid !== 1'b1 || bus.out_data !== 4'b1000) begin
            n_err++; $display("FAIL wr_with_accept: valid=%b data=%b want 1/1000", bus.out_valid, bus.out_data);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_rst_mid_lookup();
        logic [3:0] res;
        bit to;
        bus.in_data = 8'h39;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_lookup_valid: got %b want 0", bus.out_valid); end
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_lookup_ready: got %b want 1", bus.in_ready); end
        run_word(8'h39, res, to);
        n_vec++; if (to || res !== 4'b0011) begin n_err++; $display("FAIL rst_tables_restored: got %b (to=%0d) want 0011", res, to); end
        bus.in_data = 8'hFF;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick(); tick();
        n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL rst_done_pre: got %b want 1", bus.out_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if (bus.out_valid !== 1'b0 || bus.out_data !== 4'h0) begin
            n_err++; $display("FAIL rst_done_drop: valid=%b data=%b want 0/0000", bus.out_valid, bus.out_data);
        end
    endtask

`ifdef SBOX_PARITY_EN
    task automatic test_parity();
        logic [3:0] res;
        bit to;
        rst = 1'b1; tick(); rst = 1'b0; tick();
        n_vec++; if (par_err !== 1'b0) begin n_err++; $display("FAIL par_reset: got %b want 0", par_err); end
        run_word(8'h39, res, to);
        n_vec++; if (par_err !== 1'b0) begin n_err++; $display("FAIL par_clean: got %b want 0", par_err); end
        dut.g_box[0].u_tbl.par_q[12] = ~dut.g_box[0].u_tbl.par_q[12];
        run_word(8'h39, res, to);
        n_vec++; if (to || res !== 4'b0011) begin n_err++; $display("FAIL par_data: got %b (to=%0d) want 0011", res, to); end
        n_vec++; if (par_err !== 1'b1) begin n_err++; $display("FAIL par_detect: got %b want 1", par_err); end
        run_word(8'h00, res, to);
        n_vec++; if (par_err !== 1'b1) begin n_err++; $display("FAIL par_sticky: got %b want 1", par_err); end
        rst = 1'b1; tick(); rst = 1'b0; tick();
        n_vec++; if (par_err !== 1'b0) begin n_err++; $display("FAIL par_clear: got %b want 0", par_err); end
    endtask
`endif

    initial begin
        bus.en        = 1'b1;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.tbl_we    = 1'b0;
        bus.tbl_box   = '0;
        bus.tbl_addr  = '0;
        bus.tbl_wdata = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_en_gating();
        test_table_write();
        test_rst_mid_lookup();
`ifdef SBOX_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
